axi_timer_periph: RTL

AXI_TIMER_PERIPH -- requirements
Module: axi_timer_periph

---
 rtl/axi_timer_periph.sv | 139 +++++++++++++
 1 files changed

// File: rtl/axi_timer_periph.sv
// Memory-mapped timer peripheral sitting behind an AXI4-Lite slave shim.
// Registers: CTRL (0x00), COUNT (0x04), COMPARE (0x08), STATUS (0x0C).
// An 8-bit prescaler generates ticks that advance COUNT; a COUNT==COMPARE
// hit on a tick latches MATCH, which drives the level interrupt when enabled.
module axi_timer_periph #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_write,
  input  logic [3:0]            byte_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  data_valid,
  output logic                  irq
);

  localparam logic [5:0] OffCtrl    = 6'h00;
  localparam logic [5:0] OffCount   = 6'h01;
  localparam logic [5:0] OffCompare = 6'h02;
  localparam logic [5:0] OffStatus  = 6'h03;

  // Only EN, AUTO_RELOAD, IRQ_EN and PRESCALE are implemented in CTRL.
  localparam logic [DATA_WIDTH-1:0] CtrlMask = DATA_WIDTH'(32'h0000_FF07);

  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] compare_q, compare_d;
  logic                  match_q, match_d;
  logic [7:0]            pcnt_q, pcnt_d;
  logic [DATA_WIDTH-1:0] readData_q, readData_d;
  logic                  dataValid_q, dataValid_d;
  logic [ADDR_WIDTH-1:0] readAddr_q;

  logic [5:0]            wrOff;
  logic [5:0]            rdOff;
  logic                  tick;
  logic                  isMatch;
  logic [DATA_WIDTH-1:0] countTick;
  logic                  wrCtrl, wrCount, wrCompare, wrStatus;
  logic                  unusedAddrBits;

  // Word offset within the 256-byte window; upper and byte-lane bits ignored.
  assign wrOff = write_addr[7:2];
  assign rdOff = read_addr[7:2];

  assign unusedAddrBits = ^{write_addr[ADDR_WIDTH-1:8], write_addr[1:0]};

  assign wrCtrl    = mem_write && (wrOff == OffCtrl);
  assign wrCount   = mem_write && (wrOff == OffCount);
  assign wrCompare = mem_write && (wrOff == OffCompare);
  assign wrStatus  = mem_write && (wrOff == OffStatus);

  // Replace only the byte lanes whose enable is set.
  function automatic logic [DATA_WIDTH-1:0] mergeBytes(
    input logic [DATA_WIDTH-1:0] oldVal,
    input logic [DATA_WIDTH-1:0] newVal,
    input logic [3:0]            be
  );
    logic [DATA_WIDTH-1:0] res;
    res = oldVal;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = newVal[8*i +: 8];
    end
    return res;
  endfunction

  // Next-state logic: prescaler, counter, match flag, register writes, read mux.
  always_comb begin
    tick    = ctrl_q[0] && (pcnt_q == ctrl_q[15:8]);
    isMatch = (count_q == compare_q);

    pcnt_d = 8'd0;
    if (ctrl_q[0] && !tick) pcnt_d = pcnt_q + 8'd1;

    countTick = count_q;
    if (tick) begin
      if (isMatch && ctrl_q[1]) countTick = '0;
      else                      countTick = count_q + DATA_WIDTH'(1);
    end

    // A software write to COUNT overrides the ticked value on its written lanes.
    count_d = countTick;
    if (wrCount) count_d = mergeBytes(countTick, write_data, byte_en);

    ctrl_d = ctrl_q;
    if (wrCtrl) ctrl_d = mergeBytes(ctrl_q, write_data, byte_en) & CtrlMask;

    compare_d = compare_q;
    if (wrCompare) compare_d = mergeBytes(compare_q, write_data, byte_en);

    // A same-cycle hardware match beats the software clear.
    match_d = match_q;
    if (wrStatus && byte_en[0] && write_data[0]) match_d = 1'b0;
    if (tick && isMatch) match_d = 1'b1;

    readData_d = '0;
    case (rdOff)
      OffCtrl:    readData_d = ctrl_q;
      OffCount:   readData_d = count_q;
      OffCompare: readData_d = compare_q;
      OffStatus:  readData_d = {{(DATA_WIDTH-1){1'b0}}, match_q};
      default:    readData_d = '0;
    endcase

    dataValid_d = (read_addr == readAddr_q);
  end

  // State registers with synchronous reset; writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= '0;
      count_q     <= '0;
      compare_q   <= '0;
      match_q     <= 1'b0;
      pcnt_q      <= 8'd0;
      readData_q  <= '0;
      dataValid_q <= 1'b0;
      readAddr_q  <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      match_q     <= match_d;
      pcnt_q      <= pcnt_d;
      readData_q  <= readData_d;
      dataValid_q <= dataValid_d;
      readAddr_q  <= read_addr;
    end
  end

  assign read_data  = readData_q;
  assign data_valid = dataValid_q;
  assign irq        = match_q & ctrl_q[2];

endmodule
